// File: rtl/tx_pulse_scheduler.sv
// tx_pulse_scheduler
//
// Schedules bursts of transmit pulses for a downstream code generator. A
// burst starts when start is seen in IDLE. At that point every configuration
// word is latched into shadow registers. The configuration is validated for
// one cycle. After that, sinc is high for on_time = num_dig * tiempo_b cycles
// of every periodo-cycle interval. The burst lasts until n_pulsos pulses have
// been sent, or until abort when n_pulsos is zero.
//
// Build option: define TX_ALT_CODE_EN to alternate codigo_a (even pulses) and
// codigo_b (odd pulses) on codigo_o. When it is undefined, codigo_o is always
// codigo_a and codigo_b is ignored.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-low reset
//   start, abort    begin a burst (sampled in IDLE) / terminate a burst
//   num_dig         code digits per pulse
//   tiempo_b        clocks per digit
//   periodo         pulse repetition interval in clocks
//   n_pulsos        pulses per burst, 0 = continuous
//   codigo_a/_b     code words, LSB transmitted first
//   sinc            pulse gate to the code generator
//   codigo_o        code word for the current/next pulse
//   num_dig_o       shadowed num_dig, stable for the whole burst
//   tiempo_b_o      shadowed tiempo_b, stable for the whole burst
//   busy            high from CHECK through the last GUARD cycle
//   done            one-cycle end-of-burst strobe
//   err_cfg         configuration rejected; held until the next accepted start
//   pulse_idx       index of the current pulse within the burst
module tx_pulse_scheduler #(
    parameter int unsigned NB_REG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NB_REG-1:0] num_dig,
    input  logic [NB_REG-1:0] tiempo_b,
    input  logic [NB_REG-1:0] periodo,
    input  logic [NB_REG-1:0] n_pulsos,
    input  logic [NB_REG-1:0] codigo_a,
    input  logic [NB_REG-1:0] codigo_b,
    output logic              sinc,
    output logic [NB_REG-1:0] codigo_o,
    output logic [NB_REG-1:0] num_dig_o,
    output logic [NB_REG-1:0] tiempo_b_o,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic [NB_REG-1:0] pulse_idx
);

    localparam int unsigned NbWide = 2 * NB_REG;
    localparam logic [NB_REG-1:0] MaxDig = NB_REG'(NB_REG);

    typedef enum logic [2:0] {StIdle, StCheck, StActive, StGuard, StDone} state_e;

    state_e state_q, state_d;

    logic [NB_REG-1:0] num_dig_q, tiempo_b_q, periodo_q, n_pulsos_q;
    logic [NB_REG-1:0] codigo_a_q, codigo_b_q;
    logic [NB_REG-1:0] on_time_q, on_time_d;
    logic [NB_REG-1:0] cnt_q, cnt_d;
    logic [NB_REG-1:0] pulse_idx_q, pulse_idx_d;
    logic [NB_REG-1:0] codigo_q, codigo_d;
    logic              err_q, err_d;
    logic              load_cfg;

    logic [NbWide-1:0] on_time_full;
    logic [NB_REG-1:0] guard_len;
    logic [NB_REG-1:0] pulse_idx_inc;
    logic [NB_REG-1:0] next_code;
    logic              cfg_bad;
    logic              more_pulses;

    // Full-width product so that an oversized on_time cannot alias below periodo.
    assign on_time_full = NbWide'(num_dig_q) * NbWide'(tiempo_b_q);
    assign cfg_bad = (num_dig_q == '0) || (num_dig_q > MaxDig) || (tiempo_b_q == '0) ||
                     (on_time_full >= NbWide'(periodo_q));

    // on_time < periodo once validated, so both fit in NB_REG bits.
    assign guard_len     = periodo_q - on_time_q;
    assign pulse_idx_inc = pulse_idx_q + NB_REG'(1);
    assign more_pulses   = (n_pulsos_q == '0) || (pulse_idx_inc != n_pulsos_q);

`ifdef TX_ALT_CODE_EN
    // The code is loaded for the upcoming pulse pulse_idx+1, whose parity is the
    // opposite of the current index.
    assign next_code = pulse_idx_q[0] ? codigo_a_q : codigo_b_q;
`else
    assign next_code = codigo_a_q;

    logic unused_codigo_b;
    assign unused_codigo_b = ^{codigo_b, codigo_b_q};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        on_time_d   = on_time_q;
        pulse_idx_d = pulse_idx_q;
        codigo_d    = codigo_q;
        err_d       = err_q;
        load_cfg    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load_cfg    = 1'b1;
                    err_d       = 1'b0;
                    pulse_idx_d = '0;
                    // Pulse 0 always uses codigo_a. It is presented during CHECK,
                    // which is the cycle before the first sinc rise.
                    codigo_d    = codigo_a;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    on_time_d = on_time_full[NB_REG-1:0];
                    cnt_d     = on_time_full[NB_REG-1:0] - NB_REG'(1);
                    state_d   = StActive;
                end
            end
            StActive: begin
                if (cnt_q == '0) begin
                    cnt_d   = guard_len - NB_REG'(1);
                    state_d = StGuard;
                    // A one-cycle guard is itself the cycle before the next rise.
                    if (guard_len == NB_REG'(1) && more_pulses) begin
                        codigo_d = next_code;
                    end
                end else begin
                    cnt_d = cnt_q - NB_REG'(1);
                end
            end
            StGuard: begin
                if (cnt_q == '0) begin
                    pulse_idx_d = pulse_idx_inc;
                    if (more_pulses) begin
                        cnt_d   = on_time_q - NB_REG'(1);
                        state_d = StActive;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - NB_REG'(1);
                    if (cnt_q == NB_REG'(1) && more_pulses) begin
                        codigo_d = next_code;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // abort overrides everything, including a simultaneous start in IDLE.
        if (abort) begin
            state_d     = StIdle;
            cnt_d       = cnt_q;
            on_time_d   = on_time_q;
            pulse_idx_d = pulse_idx_q;
            codigo_d    = codigo_q;
            err_d       = err_q;
            load_cfg    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            on_time_q   <= '0;
            pulse_idx_q <= '0;
            codigo_q    <= '0;
            err_q       <= 1'b0;
            num_dig_q   <= '0;
            tiempo_b_q  <= '0;
            periodo_q   <= '0;
            n_pulsos_q  <= '0;
            codigo_a_q  <= '0;
            codigo_b_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            on_time_q   <= on_time_d;
            pulse_idx_q <= pulse_idx_d;
            codigo_q    <= codigo_d;
            err_q       <= err_d;
            if (load_cfg) begin
                num_dig_q  <= num_dig;
                tiempo_b_q <= tiempo_b;
                periodo_q  <= periodo;
                n_pulsos_q <= n_pulsos;
                codigo_a_q <= codigo_a;
                codigo_b_q <= codigo_b;
            end
        end
    end

    assign sinc       = (state_q == StActive);
    assign busy       = (state_q == StCheck) || (state_q == StActive) || (state_q == StGuard);
    assign done       = (state_q == StDone);
    assign err_cfg    = err_q;
    assign pulse_idx  = pulse_idx_q;
    assign codigo_o   = codigo_q;
    assign num_dig_o  = num_dig_q;
    assign tiempo_b_o = tiempo_b_q;

endmodule

// File: tb/tb_tx_pulse_scheduler.sv
// Self-checking bench for tx_pulse_scheduler. The expected outputs come from
// the burst timing rules, expressed as plain arithmetic on the cycle offset
// from the start edge. Bursts are directed and randomized; configuration
// inputs are scrambled while a burst is running.
module tb_tx_pulse_scheduler;

    localparam int unsigned NB = 32;

`ifdef TX_ALT_CODE_EN
    localparam bit Alt = 1'b1;
`else
    localparam bit Alt = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] nd;
        logic [31:0] tb;
        logic [31:0] per;
        logic [31:0] n;
        logic [31:0] ca;
        logic [31:0] cb;
    } cfg_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NB-1:0] num_dig, tiempo_b, periodo, n_pulsos, codigo_a, codigo_b;
    logic          sinc, busy, done, err_cfg;
    logic [NB-1:0] codigo_o, num_dig_o, tiempo_b_o, pulse_idx;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    tx_pulse_scheduler #(.NB_REG(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_dig    (num_dig),
        .tiempo_b   (tiempo_b),
        .periodo    (periodo),
        .n_pulsos   (n_pulsos),
        .codigo_a   (codigo_a),
        .codigo_b   (codigo_b),
        .sinc       (sinc),
        .codigo_o   (codigo_o),
        .num_dig_o  (num_dig_o),
        .tiempo_b_o (tiempo_b_o),
        .busy       (busy),
        .done       (done),
        .err_cfg    (err_cfg),
        .pulse_idx  (pulse_idx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cfg_t mk_cfg(input logic [31:0] nd, input logic [31:0] tb,
                                    input logic [31:0] per, input logic [31:0] n,
                                    input logic [31:0] ca, input logic [31:0] cb);
        cfg_t c;
        c.nd = nd; c.tb = tb; c.per = per; c.n = n; c.ca = ca; c.cb = cb;
        return c;
    endfunction

    // Expected pulse_idx at offset t (t = 1 is the cycle after the start edge).
    function automatic logic [31:0] exp_pidx(input int unsigned t, input cfg_t c);
        if (t <= 1) return 32'd0;
        if (c.n != 0 && t >= 2 + c.n * c.per) return c.n;
        return (t - 2) / c.per;
    endfunction

    function automatic logic [31:0] code_for(input logic [31:0] k, input cfg_t c);
        return (Alt && k[0]) ? c.cb : c.ca;
    endfunction

    task automatic drive_cfg(input cfg_t c);
        num_dig  = c.nd;
        tiempo_b = c.tb;
        periodo  = c.per;
        n_pulsos = c.n;
        codigo_a = c.ca;
        codigo_b = c.cb;
    endtask

    // Runs one valid burst. abort_t > 0 means abort is sampled at edge abort_t.
    task automatic run_burst(input cfg_t c, input int unsigned abort_t, input bit scramble,
                             output int unsigned rises);
        int unsigned on_t, end_t, stop_t, exp_rises;
        bit          fin, aborted, e_sinc, e_busy, e_done, prev, e_prev;
        logic [31:0] e_pidx;
        on_t   = c.nd * c.tb;
        fin    = (c.n != 0);
        end_t  = fin ? 2 + c.n * c.per : 32'hFFFF_FFF0;
        stop_t = (abort_t > 0 && abort_t < end_t) ? abort_t : end_t;
        rises = 0; exp_rises = 0; prev = 1'b0; e_prev = 1'b0;
        drive_cfg(c);
        abort = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int unsigned t = 1; t <= stop_t + 1; t++) begin
            if (t > 1) begin
                @(posedge clk); #1;
            end
            abort   = 1'b0;
            aborted = (abort_t > 0) && (t >= abort_t);
            if (aborted) begin
                e_sinc = 0; e_busy = 0; e_done = 0; e_pidx = exp_pidx(abort_t - 1, c);
            end else if (t == 1) begin
                e_sinc = 0; e_busy = 1; e_done = 0; e_pidx = 0;
            end else if (fin && t >= end_t) begin
                e_sinc = 0; e_busy = 0; e_done = (t == end_t); e_pidx = c.n;
            end else begin
                e_sinc = ((t - 2) % c.per) < on_t; e_busy = 1; e_done = 0;
                e_pidx = (t - 2) / c.per;
            end
            check_eq("sinc", 64'(sinc), 64'(e_sinc));
            check_eq("busy", 64'(busy), 64'(e_busy));
            check_eq("done", 64'(done), 64'(e_done));
            check_eq("err_cfg", 64'(err_cfg), 64'd0);
            check_eq("pulse_idx", 64'(pulse_idx), 64'(e_pidx));
            check_eq("num_dig_o", 64'(num_dig_o), 64'(c.nd));
            check_eq("tiempo_b_o", 64'(tiempo_b_o), 64'(c.tb));
            if (!aborted) begin
                if (e_sinc) begin
                    check_eq("codigo_o_on", 64'(codigo_o), 64'(code_for((t - 2) / c.per, c)));
                end else if (((t - 1) % c.per) == 0 && (!fin || (t - 1) / c.per < c.n)) begin
                    check_eq("codigo_o_pre", 64'(codigo_o), 64'(code_for((t - 1) / c.per, c)));
                end
            end
            if (sinc && !prev) rises++;
            if (e_sinc && !e_prev) exp_rises++;
            prev   = sinc;
            e_prev = e_sinc;
            if (scramble && t < stop_t) begin
                num_dig  = $urandom; tiempo_b = $urandom; periodo  = $urandom;
                n_pulsos = $urandom; codigo_a = $urandom; codigo_b = $urandom;
                start    = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (abort_t > 0 && t + 1 == abort_t) abort = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        check_eq("rises", 64'(rises), 64'(exp_rises));
    endtask

    task automatic run_bad(input cfg_t c);
        drive_cfg(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("bad_chk_busy", 64'(busy), 64'd1);
        check_eq("bad_chk_err", 64'(err_cfg), 64'd0);
        check_eq("bad_chk_sinc", 64'(sinc), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("bad_err", 64'(err_cfg), 64'd1);
            check_eq("bad_busy", 64'(busy), 64'd0);
            check_eq("bad_sinc", 64'(sinc), 64'd0);
            check_eq("bad_done", 64'(done), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_sinc"}, 64'(sinc), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_err"}, 64'(err_cfg), 64'd0);
        check_eq({tag, "_pidx"}, 64'(pulse_idx), 64'd0);
        check_eq({tag, "_code"}, 64'(codigo_o), 64'd0);
        check_eq({tag, "_nd"}, 64'(num_dig_o), 64'd0);
        check_eq({tag, "_tb"}, 64'(tiempo_b_o), 64'd0);
    endtask

    initial begin
        cfg_t        c;
        int unsigned r, on_t, end_t, ab;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        drive_cfg(mk_cfg(0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic 3-pulse burst, with config scrambled mid-burst.
        run_burst(mk_cfg(4, 3, 20, 3, 32'h5, 32'hA), 0, 1'b1, r);
        check_eq("burst_rises", 64'(r), 64'd3);
        check_eq("burst_pidx", 64'(pulse_idx), 64'd3);

        // Code alternation pattern.
        run_burst(mk_cfg(4, 3, 20, 4, 32'h5, 32'hA), 0, 1'b0, r);

        // Rejected configurations, then a valid start clears err_cfg.
        run_bad(mk_cfg(5, 4, 20, 1, 1, 2));
        run_burst(mk_cfg(2, 2, 9, 2, 32'h33, 32'h44), 0, 1'b0, r);
        run_bad(mk_cfg(0, 3, 20, 1, 1, 2));
        run_bad(mk_cfg(33, 1, 100, 1, 1, 2));
        run_bad(mk_cfg(2, 0, 20, 1, 1, 2));
        run_burst(mk_cfg(1, 1, 2, 1, 32'h7, 32'h8), 0, 1'b0, r);

        // Boundaries: one-cycle guard and num_dig equal to the word width.
        run_burst(mk_cfg(3, 3, 10, 3, 32'h11, 32'h22), 0, 1'b1, r);
        run_burst(mk_cfg(32, 1, 33, 2, 32'hDEAD, 32'hBEEF), 0, 1'b0, r);

        // Abort during the second ACTIVE of a 5-pulse burst.
        run_burst(mk_cfg(2, 3, 10, 5, 32'h1, 32'h2), 14, 1'b0, r);
        check_eq("abort_rises", 64'(r), 64'd2);

        // Continuous mode, abort right after the tenth full period.
        run_burst(mk_cfg(2, 2, 7, 0, 32'hC, 32'hD), 72, 1'b1, r);
        check_eq("cont_rises", 64'(r), 64'd10);

        // start and abort together in IDLE.
        drive_cfg(mk_cfg(2, 2, 7, 1, 1, 2));
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check_eq("startabort_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check_eq("startabort_busy2", 64'(busy), 64'd0);
        check_eq("startabort_sinc", 64'(sinc), 64'd0);

        // Reset in the middle of the first GUARD.
        drive_cfg(mk_cfg(4, 3, 20, 3, 32'h9, 32'h6));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_eq("pre_rst_sinc", 64'(sinc), 64'd0);
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midrst");
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_done", 64'(done), 64'd0);
        check_eq("post_rst_sinc", 64'(sinc), 64'd0);

        // Randomized bursts, some aborted, all with scrambled config.
        for (int i = 0; i < 16; i++) begin
            c.nd  = $urandom_range(1, 6);
            c.tb  = $urandom_range(1, 4);
            on_t  = c.nd * c.tb;
            c.per = on_t + $urandom_range(1, 6);
            c.n   = $urandom_range(1, 4);
            c.ca  = $urandom;
            c.cb  = $urandom;
            end_t = 2 + c.n * c.per;
            ab    = ($urandom_range(0, 2) == 0) ? $urandom_range(2, end_t - 1) : 0;
            run_burst(c, ab, 1'b1, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
